// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder
// Turns bytes from the SPI byte shifter (already in the clk_i domain) into
// single-beat bus read/write requests. A frame (/CS low) carries one command:
//   cmd[7:6] = 00 READ       : cmd, addr_hi, addr_lo
//              01 WRITE      : cmd, addr_hi, addr_lo, data
//              10 READ_NEXT  : cmd                 (address = addr + 1)
//              11 WRITE_NEXT : cmd, data           (address = addr + 1)
//   cmd[0] is A16 for READ/WRITE; cmd[5:1] are ignored.
// Read data is returned on tx_data_o for the shifter's next frame.
//
// Ports:
//   clk_i, reset_i        clock, async active-high reset
//   spi_cs_ni             /CS (synchronized), high = no frame
//   rx_data_i, rx_valid_i received byte + one-cycle strobe
//   tx_data_o             last read data, held between reads
//   bus_req_o/we_o/addr_o/wdata_o, bus_rdata_i, bus_ack_i  req/ack bus
//   busy_o                command in progress until its ack
//   overrun_o             sticky: byte arrived while a request was pending
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a command byte
// ADDR_HI | waiting for address bits [15:8]
// ADDR_LO | waiting for address bits [7:0]
// DATA    | waiting for the write data byte
// REQ     | bus_req_o held high until bus_ack_i
// DONE    | transaction finished, extra bytes ignored until /CS rises

module spi_cmd_decoder #(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  spi_cs_ni,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic [7:0]            tx_data_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [7:0]            bus_wdata_o,
  input  logic [7:0]            bus_rdata_i,
  input  logic                  bus_ack_i,
  output logic                  busy_o,
  output logic                  overrun_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_DATA,
    S_REQ,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_READ       = 2'b00;
  localparam logic [1:0] OP_WRITE      = 2'b01;
  localparam logic [1:0] OP_READ_NEXT  = 2'b10;
  localparam logic [1:0] OP_WRITE_NEXT = 2'b11;

  state_t                state_q;
  logic [1:0]            op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_inc_d;
  logic [7:0]            wdata_q;
  logic [7:0]            tx_q;
  logic                  req_q;
  logic                  we_q;
  logic                  busy_q;
  logic                  overrun_q;
  logic                  byte_ok_d;

  // A byte counts only while /CS is low; a byte coinciding with /CS rising
  // is therefore dropped.
  assign byte_ok_d  = rx_valid_i & ~spi_cs_ni;
  // Natural wrap 2^ADDR_WIDTH-1 -> 0 from the fixed-width add.
  assign addr_inc_d = addr_q + ADDR_WIDTH'(1);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      op_q      <= OP_READ;
      addr_q    <= '0;
      wdata_q   <= '0;
      tx_q      <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (byte_ok_d) begin
            op_q   <= rx_data_i[7:6];
            busy_q <= 1'b1;
            case (rx_data_i[7:6])
              OP_READ, OP_WRITE: begin
                addr_q[16] <= rx_data_i[0];
                state_q    <= S_ADDR_HI;
              end
              OP_READ_NEXT: begin
                addr_q  <= addr_inc_d;
                we_q    <= 1'b0;
                req_q   <= 1'b1;
                state_q <= S_REQ;
              end
              default: state_q <= S_DATA;
            endcase
          end
        end

        // Aborts leave addr_q partially loaded on purpose: a following
        // *_NEXT command builds on whatever was received.
        S_ADDR_HI: begin
          if (spi_cs_ni) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (rx_valid_i) begin
            addr_q[15:8] <= rx_data_i;
            state_q      <= S_ADDR_LO;
          end
        end

        S_ADDR_LO: begin
          if (spi_cs_ni) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (rx_valid_i) begin
            addr_q[7:0] <= rx_data_i;
            if (op_q == OP_READ) begin
              we_q    <= 1'b0;
              req_q   <= 1'b1;
              state_q <= S_REQ;
            end else begin
              state_q <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (spi_cs_ni) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (rx_valid_i) begin
            wdata_q <= rx_data_i;
            if (op_q == OP_WRITE_NEXT) begin
              addr_q <= addr_inc_d;
            end
            we_q    <= 1'b1;
            req_q   <= 1'b1;
            state_q <= S_REQ;
          end
        end

        // addr_q and we_q are never written here, so they stay stable
        // for the whole request.
        S_REQ: begin
          if (byte_ok_d) begin
            overrun_q <= 1'b1;
          end
          if (bus_ack_i) begin
            req_q  <= 1'b0;
            busy_q <= 1'b0;
            if (!we_q) begin
              tx_q <= bus_rdata_i;
            end
            state_q <= spi_cs_ni ? S_IDLE : S_DONE;
          end
        end

        S_DONE: begin
          if (spi_cs_ni) begin
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_data_o   = tx_q;
  assign bus_req_o   = req_q;
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign busy_o      = busy_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder. Inputs change on the falling edge and
// outputs are checked on the falling edge, away from the active rising edge.
module tb_spi_cmd_decoder;

  localparam int AW = 17;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          spi_cs_ni;
  logic [7:0]    rx_data_i;
  logic          rx_valid_i;
  logic [7:0]    tx_data_o;
  logic          bus_req_o;
  logic          bus_we_o;
  logic [AW-1:0] bus_addr_o;
  logic [7:0]    bus_wdata_o;
  logic [7:0]    bus_rdata_i;
  logic          bus_ack_i;
  logic          busy_o;
  logic          overrun_o;

  int tests  = 0;
  int failed = 0;
  int txn_count = 0;

  spi_cmd_decoder #(.ADDR_WIDTH(AW)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .spi_cs_ni   (spi_cs_ni),
    .rx_data_i   (rx_data_i),
    .rx_valid_i  (rx_valid_i),
    .tx_data_o   (tx_data_o),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_rdata_i (bus_rdata_i),
    .bus_ack_i   (bus_ack_i),
    .busy_o      (busy_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  // Completed transactions: ack seen while a request is up.
  always @(posedge clk_i) begin
    if (bus_req_o && bus_ack_i) txn_count <= txn_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    @(negedge clk_i);
    rx_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Hold off the ack for wait_cyc cycles, then pulse it for one cycle.
  task automatic ack_after(input int wait_cyc, input logic [7:0] rdata);
    idle(wait_cyc);
    bus_rdata_i = rdata;
    bus_ack_i   = 1'b1;
    @(negedge clk_i);
    bus_ack_i   = 1'b0;
  endtask

  task automatic frame_gap();
    spi_cs_ni = 1'b1;
    idle(2);
    spi_cs_ni = 1'b0;
  endtask

  initial begin
    int txn_before;
    reset_i     = 1'b1;
    spi_cs_ni   = 1'b1;
    rx_data_i   = 8'h00;
    rx_valid_i  = 1'b0;
    bus_rdata_i = 8'h00;
    bus_ack_i   = 1'b0;
    idle(2);
    check("reset_req",   {31'd0, bus_req_o}, 32'd0);
    check("reset_addr",  {15'd0, bus_addr_o}, 32'd0);
    check("reset_tx",    {24'd0, tx_data_o}, 32'd0);
    reset_i = 1'b0;
    idle(1);

    // Reset mid-frame after cmd 0x01 and addr_hi 0x80.
    spi_cs_ni = 1'b0;
    send_byte(8'h01);
    send_byte(8'h80);
    check("midframe_busy", {31'd0, busy_o}, 32'd1);
    #2 reset_i = 1'b1;
    #1;
    check("async_rst_busy", {31'd0, busy_o}, 32'd0);
    check("async_rst_addr", {15'd0, bus_addr_o}, 32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    frame_gap();

    // WRITE 0x41,0x80,0x00,0x5A -> write 0x5A to 0x18000.
    send_byte(8'h41);
    send_byte(8'h80);
    send_byte(8'h00);
    check("wr_no_req_early", {31'd0, bus_req_o}, 32'd0);
    send_byte(8'h5A);
    check("wr_req",   {31'd0, bus_req_o}, 32'd1);
    check("wr_we",    {31'd0, bus_we_o}, 32'd1);
    check("wr_addr",  {15'd0, bus_addr_o}, 32'h18000);
    check("wr_wdata", {24'd0, bus_wdata_o}, 32'h5A);
    check("wr_busy",  {31'd0, busy_o}, 32'd1);
    idle(2);
    check("wr_req_held",  {31'd0, bus_req_o}, 32'd1);
    check("wr_addr_held", {15'd0, bus_addr_o}, 32'h18000);
    ack_after(0, 8'hEE);
    check("wr_req_drop", {31'd0, bus_req_o}, 32'd0);
    check("wr_busy_drop", {31'd0, busy_o}, 32'd0);
    check("wr_tx_unchanged", {24'd0, tx_data_o}, 32'h00);
    frame_gap();

    // READ 0x00,0xE8,0x10 -> read 0x0E810, returns 0xA5.
    send_byte(8'h00);
    send_byte(8'hE8);
    send_byte(8'h10);
    check("rd_req",  {31'd0, bus_req_o}, 32'd1);
    check("rd_we",   {31'd0, bus_we_o}, 32'd0);
    check("rd_addr", {15'd0, bus_addr_o}, 32'h0E810);
    ack_after(1, 8'hA5);
    check("rd_tx", {24'd0, tx_data_o}, 32'hA5);
    frame_gap();

    // READ_NEXT twice.
    send_byte(8'h80);
    check("rn1_req",  {31'd0, bus_req_o}, 32'd1);
    check("rn1_addr", {15'd0, bus_addr_o}, 32'h0E811);
    ack_after(0, 8'h11);
    check("rn1_tx", {24'd0, tx_data_o}, 32'h11);
    frame_gap();
    send_byte(8'h80);
    check("rn2_addr", {15'd0, bus_addr_o}, 32'h0E812);
    ack_after(0, 8'h12);
    check("rn2_tx", {24'd0, tx_data_o}, 32'h12);
    frame_gap();

    // Wrap: READ 0x1FFFF, then READ_NEXT -> 0x00000.
    send_byte(8'h01);
    send_byte(8'hFF);
    send_byte(8'hFF);
    check("wrap_base", {15'd0, bus_addr_o}, 32'h1FFFF);
    ack_after(0, 8'h3C);
    frame_gap();
    send_byte(8'h80);
    check("wrap_addr", {15'd0, bus_addr_o}, 32'h00000);
    ack_after(0, 8'h4D);
    check("wrap_tx", {24'd0, tx_data_o}, 32'h4D);

    // Byte with /CS high is ignored.
    spi_cs_ni = 1'b1;
    idle(1);
    send_byte(8'h80);
    idle(1);
    check("cs_high_byte_ignored", {31'd0, bus_req_o}, 32'd0);
    spi_cs_ni = 1'b0;

    // Abort a WRITE after cmd + addr_hi: addr becomes 0x11200, no request.
    send_byte(8'h41);
    send_byte(8'h12);
    spi_cs_ni = 1'b1;
    idle(3);
    check("abort_no_req", {31'd0, bus_req_o}, 32'd0);
    check("abort_busy",   {31'd0, busy_o}, 32'd0);
    spi_cs_ni = 1'b0;
    send_byte(8'hC0);
    send_byte(8'h33);
    check("wn_req",   {31'd0, bus_req_o}, 32'd1);
    check("wn_we",    {31'd0, bus_we_o}, 32'd1);
    check("wn_addr",  {15'd0, bus_addr_o}, 32'h11201);
    check("wn_wdata", {24'd0, bus_wdata_o}, 32'h33);
    ack_after(0, 8'h99);
    check("wn_tx_unchanged", {24'd0, tx_data_o}, 32'h4D);
    frame_gap();

    // Overrun: extra byte while ack withheld 10 cycles; /CS rises during REQ.
    txn_before = txn_count;
    check("pre_overrun", {31'd0, overrun_o}, 32'd0);
    send_byte(8'h80);
    check("ov_addr", {15'd0, bus_addr_o}, 32'h11202);
    idle(1);
    send_byte(8'h55);
    check("ov_set", {31'd0, overrun_o}, 32'd1);
    check("ov_req_kept", {31'd0, bus_req_o}, 32'd1);
    check("ov_addr_kept", {15'd0, bus_addr_o}, 32'h11202);
    spi_cs_ni = 1'b1;
    idle(2);
    check("ov_req_cs_high", {31'd0, bus_req_o}, 32'd1);
    ack_after(5, 8'h77);
    check("ov_req_drop", {31'd0, bus_req_o}, 32'd0);
    check("ov_tx", {24'd0, tx_data_o}, 32'h77);
    check("ov_one_txn", txn_count - txn_before, 32'd1);
    idle(3);
    check("ov_sticky", {31'd0, overrun_o}, 32'd1);
    check("ov_no_extra_req", {31'd0, bus_req_o}, 32'd0);

    // Back in IDLE: a new READ_NEXT decodes normally.
    spi_cs_ni = 1'b0;
    send_byte(8'h80);
    check("post_ov_addr", {15'd0, bus_addr_o}, 32'h11203);
    ack_after(0, 8'h01);
    check("post_ov_sticky", {31'd0, overrun_o}, 32'd1);
    spi_cs_ni = 1'b1;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
